// File: rtl/clint_rtc_ctrl.sv
// clint_rtc_ctrl: programmable RTC tick generator for the CLINT rtc_i input,
// with enable, runtime divisor, debug-halt freeze and a tick counter.
module clint_rtc_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        debug_halt_i,
    input  logic        cfg_req_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_gnt_o,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic        rtc_o,
    output logic        rtc_tick_o
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                state;
    logic                  en, hod;
    logic [DIV_WIDTH-1:0]  div, per, cnt;
    logic [31:0]           tickcnt;
    logic                  wr, halt, wrap;
    logic [DIV_WIDTH-1:0]  div_eff, cnt_inc;
    logic [31:0]           rd_mux;

    assign cfg_gnt_o = cfg_req_i;
    assign wr        = cfg_req_i & cfg_we_i;
    assign halt      = hod & debug_halt_i;
    assign div_eff   = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
    assign cnt_inc   = cnt + DIV_WIDTH'(1);
    assign wrap      = cnt == per - DIV_WIDTH'(1);

    always_comb
        rd_mux = (cfg_addr_i == 2'd0) ? {30'b0, hod, en} :
                 (cfg_addr_i == 2'd1) ? 32'(div) :
                 (cfg_addr_i == 2'd2) ? tickcnt : 32'b0;

    // FSM and register file share one block; the FSM sees the pre-write
    // register values, so config writes act the cycle after grant.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            en           <= AUTO_START;
            hod          <= 1'b0;
            div          <= DIV_WIDTH'(DEFAULT_DIV);
            per          <= DIV_WIDTH'(2);
            cnt          <= '0;
            tickcnt      <= '0;
            rtc_o        <= 1'b0;
            rtc_tick_o   <= 1'b0;
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_rdata_o  <= (cfg_req_i & ~cfg_we_i) ? rd_mux : 32'b0;
            if (wr && cfg_addr_i == 2'd0) begin
                en  <= cfg_wdata_i[0];
                hod <= cfg_wdata_i[1];
            end
            if (wr && cfg_addr_i == 2'd1)
                div <= cfg_wdata_i[DIV_WIDTH-1:0];
            tickcnt    <= (wr && cfg_addr_i == 2'd2) ? cfg_wdata_i : tickcnt + 32'(rtc_tick_o);
            rtc_tick_o <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    state      <= RUN;
                    cnt        <= '0;
                    per        <= div_eff;
                    rtc_o      <= 1'b1;
                    rtc_tick_o <= 1'b1;
                end
                RUN, HALTED: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                        rtc_o <= 1'b0;
                    end else if (halt) begin
                        state <= HALTED;
                    end else begin
                        state      <= RUN;
                        cnt        <= wrap ? '0 : cnt_inc;
                        per        <= wrap ? div_eff : per;
                        rtc_o      <= wrap | (cnt_inc < (per >> 1));
                        rtc_tick_o <= wrap;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_rtc_ctrl.sv
// tb_clint_rtc_ctrl: directed table, corner sequences and randomized traffic
// checked against a cycle-level behavioural model of the RTC controller.
module tb_clint_rtc_ctrl;
    logic        aclk = 1'b0;
    logic        areset, debug_halt_i, cfg_req_i, cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic        cfg_gnt_o, cfg_rvalid_o, rtc_o, rtc_tick_o;
    logic [31:0] cfg_rdata_o;

    int checks = 0, errors = 0;

    clint_rtc_ctrl dut (
        .aclk(aclk), .areset(areset), .debug_halt_i(debug_halt_i),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
        .cfg_rdata_o(cfg_rdata_o), .rtc_o(rtc_o), .rtc_tick_o(rtc_tick_o)
    );

    always #5 aclk = ~aclk;

    // Model: m_pos is the position inside the current period, m_on says
    // whether the generator is running (running or frozen), m_tick is the
    // pulse visible in the current cycle.
    bit          m_on, m_tick, m_en, m_hod, m_rv;
    int          m_pos, m_p;
    logic [15:0] m_div;
    logic [31:0] m_tc, m_rd;

    typedef struct {
        logic        req, we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        rtc, tick, rv;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[8];

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_tick = 0; m_en = 1; m_hod = 0; m_rv = 0;
        m_pos = 0; m_p = 2; m_div = 16'd2; m_tc = 0; m_rd = 0;
    endtask

    task automatic check_model();
        chk("rtc", rtc_o, (m_on && m_pos < m_p / 2));
        chk("tick", rtc_tick_o, m_tick);
        chk("rvalid", cfg_rvalid_o, m_rv);
        chk("rdata", cfg_rdata_o, m_rd);
    endtask

    // Drive one cycle of inputs (called just after a negedge), advance the
    // model across the coming posedge, then compare at the next negedge.
    task automatic step(input logic req, input logic we, input logic [1:0] addr,
                        input logic [31:0] wd, input logic dbg);
        logic [31:0] regv;
        bit wr;
        cfg_req_i = req; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd; debug_halt_i = dbg;
        #1 chk("gnt", cfg_gnt_o, req);
        wr   = req && we;
        regv = (addr == 0) ? {30'b0, m_hod, m_en} : (addr == 1) ? 32'(m_div) :
               (addr == 2) ? m_tc : 32'b0;
        m_rv = req;
        m_rd = (req && !we) ? regv : 32'b0;
        m_tc = (wr && addr == 2) ? wd : m_tc + 32'(m_tick);
        if (!m_on) begin
            m_on = m_en; m_pos = 0; m_p = eff(int'(m_div)); m_tick = m_en;
        end else if (!m_en) begin
            m_on = 0; m_pos = 0; m_tick = 0;
        end else if (m_hod && dbg) begin
            m_tick = 0;
        end else begin
            m_pos  = (m_pos + 1) % m_p;
            m_tick = (m_pos == 0);
            if (m_tick) m_p = eff(int'(m_div));
        end
        if (wr && addr == 0) begin m_en = wd[0]; m_hod = wd[1]; end
        if (wr && addr == 1) m_div = wd[15:0];
        @(posedge aclk);
        @(negedge aclk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'd0, 0);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 40 && !rtc_tick_o; i++) step(0, 0, 2'd0, 32'd0, 0);
        chk("wait_tick", rtc_tick_o, 1'b1);
    endtask

    // Distance between two consecutive ticks, measured on the DUT outputs.
    task automatic period(input int exp);
        int n;
        step(0, 0, 2'd0, 32'd0, 0); wait_tick();
        step(0, 0, 2'd0, 32'd0, 0); wait_tick();
        n = 0;
        do begin
            step(0, 0, 2'd0, 32'd0, 0);
            n++;
        end while (!rtc_tick_o && n < 40);
        chk("period", n, exp);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rtc", rtc_o, 0);
        chk("rst_tick", rtc_tick_o, 0);
        chk("rst_rvalid", cfg_rvalid_o, 0);
        chk("rst_rdata", cfg_rdata_o, 0);
        areset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] wd;
        logic [1:0]  a;
        logic        r, w;
        areset = 1'b1; debug_halt_i = 0; cfg_req_i = 0; cfg_we_i = 0;
        cfg_addr_i = 0; cfg_wdata_i = 0;

        tbl[0] = '{0, 0, 2'd0, 32'h0,        1, 1, 0, 32'h0};
        tbl[1] = '{1, 0, 2'd1, 32'h0,        0, 0, 1, 32'h2};
        tbl[2] = '{1, 0, 2'd0, 32'h0,        1, 1, 1, 32'h1};
        tbl[3] = '{1, 0, 2'd2, 32'h0,        0, 0, 1, 32'h1};
        tbl[4] = '{1, 0, 2'd3, 32'h0,        1, 1, 1, 32'h0};
        tbl[5] = '{1, 1, 2'd3, 32'hFFFFFFFF, 0, 0, 1, 32'h0};
        tbl[6] = '{0, 0, 2'd0, 32'h0,        1, 1, 0, 32'h0};
        tbl[7] = '{1, 0, 2'd1, 32'h0,        0, 0, 1, 32'h2};

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wd, 0);
            chk($sformatf("tbl%0d_rtc", i), rtc_o, tbl[i].rtc);
            chk($sformatf("tbl%0d_tick", i), rtc_tick_o, tbl[i].tick);
            chk($sformatf("tbl%0d_rv", i), cfg_rvalid_o, tbl[i].rv);
            chk($sformatf("tbl%0d_rd", i), cfg_rdata_o, tbl[i].rd);
        end

        // Fresh run: 20 cycles at divide-by-two yields 10 ticks.
        do_reset();
        idle(20);
        step(1, 0, 2'd2, 32'd0, 0);
        chk("tc_20cyc", cfg_rdata_o, 32'd10);

        // TICKCNT wrap, then a write landing on a tick cycle.
        wait_tick();
        step(1, 1, 2'd2, 32'hFFFFFFFF, 0);
        idle(2);
        step(1, 0, 2'd2, 32'd0, 0);
        chk("tc_wrap", cfg_rdata_o, 32'd0);
        wait_tick();
        step(1, 1, 2'd2, 32'h55, 0);
        step(1, 0, 2'd2, 32'd0, 0);
        chk("tc_write_wins", cfg_rdata_o, 32'h55);

        // Divisor changes take effect at a period boundary.
        step(0, 0, 2'd0, 32'd0, 0);
        step(1, 1, 2'd1, 32'd5, 0);
        period(5);
        step(1, 1, 2'd1, 32'd0, 0);
        step(1, 0, 2'd1, 32'd0, 0);
        chk("div0_read", cfg_rdata_o, 32'd0);
        period(2);
        step(1, 1, 2'd1, 32'd1, 0);
        step(1, 0, 2'd1, 32'd0, 0);
        chk("div1_read", cfg_rdata_o, 32'd1);
        period(2);
        step(1, 1, 2'd1, 32'd7, 0);
        period(7);

        // Debug halt with HOD set freezes everything for 7 cycles.
        step(1, 1, 2'd0, 32'd3, 0);
        idle(2);
        for (int i = 0; i < 7; i++) step(0, 0, 2'd0, 32'd0, 1);
        idle(10);
        step(1, 1, 2'd0, 32'd1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 32'd0, 1);

        // EN=0 during the high phase, then re-enable.
        for (int i = 0; i < 20 && !(m_on && m_pos < m_p / 2); i++) step(0, 0, 2'd0, 32'd0, 0);
        step(1, 1, 2'd0, 32'd0, 0);
        step(0, 0, 2'd0, 32'd0, 0);
        chk("en0_rtc", rtc_o, 1'b0);
        idle(3);
        step(1, 1, 2'd0, 32'd1, 0);
        step(0, 0, 2'd0, 32'd0, 0);
        chk("en1_tick", rtc_tick_o, 1'b1);
        idle(3);

        // Asynchronous reset mid-period.
        wait_tick();
        #2 areset = 1'b1;
        #1;
        chk("arst_rtc", rtc_o, 0);
        chk("arst_tick", rtc_tick_o, 0);
        chk("arst_rvalid", cfg_rvalid_o, 0);
        @(negedge aclk);
        areset = 1'b0;
        model_reset();
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom % 10) < 3;
            w  = $urandom % 2;
            a  = 2'($urandom % 4);
            wd = $urandom;
            if (a == 0) begin
                wd[0] = ($urandom % 6) != 0;
                wd[1] = $urandom % 2;
            end
            if (a == 1) wd = $urandom % 8;
            step(r, w, a, wd, ($urandom % 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
